axis_uart_rx_oversampled: RTL and testbench

UART receive path with 16x oversampling and majority-vote bit decisions, for noisy or long external links. Reassembles AXI_DATA_WIDTH/DATA_BITS serial characters into one AXI-stream word and presents it on a master axis_if. It is the receive counterpart of the team's AXI-stream UART transmitter, which splits each word into characters LSB-character-first.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/axis_if.sv | 13 +
 rtl/uart_baud_tick.sv | 39 +++
 rtl/axis_uart_rx_oversampled.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axis_uart_rx_oversampled.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receive/transmit paths.
//   rx_state_t  : receiver frame FSM states
//   uart_err_t  : per-character status reported on rx_error
//   calc_div    : clock cycles per oversample tick, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_START  = 2'b01,
    ERR_STOP   = 2'b10,
    ERR_PARITY = 2'b11
  } uart_err_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Tick indices within a 16-tick bit: three votes around mid-bit, last tick ends the bit
  localparam int unsigned SMP_W = 4;
  localparam logic [SMP_W-1:0] SAMPLE_A    = 4'd7;
  localparam logic [SMP_W-1:0] SAMPLE_B    = 4'd8;
  localparam logic [SMP_W-1:0] SAMPLE_C    = 4'd9;
  localparam logic [SMP_W-1:0] SAMPLE_LAST = 4'd15;

  // Cycles per oversample tick, rounded to nearest and never below one
  function automatic int unsigned calc_div(input int unsigned clock,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned den;
    int unsigned div;
    den = baud_rate * oversample;
    div = (clock + den / 2) / den;
    return (div == 0) ? 1 : div;
  endfunction

  // Two-out-of-three majority
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-stream handshake bundle.
//   tdata/tvalid : driven by the master
//   tready       : driven by the slave
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider that pulses once every DIV
// cycles and can be restarted to phase-align ticks to a line edge.
//   clk, rst_n : clock, async active-low reset
//   restart    : zero the divider; the first tick follows DIV cycles later
//   tick_c     : one-cycle tick (combinational from the counter)
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..DIV-1, wrapping on the tick or on restart
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  assign tick_c = (cnt_q == CNT_MAX) && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_uart_rx_oversampled.sv
// UART receiver with 16x oversampling and 3-sample majority vote. Characters
// are packed LSB-character-first into an AXI-stream word held in a separate
// output register.
//   aclk, aresetn : clock, async active-low reset
//   uart_rx       : asynchronous serial input, idle high
//   m_axis        : AXI-stream master (tdata/tvalid out, tready in)
//   rx_done       : one-cycle pulse at the end of every frame
//   rx_error      : status of the last frame, held between rx_done pulses
//   overrun       : one-cycle pulse when a completed word is dropped
module axis_uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 8,
  parameter int unsigned CLOCK          = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PARITY_BITS    = 0,
  parameter int unsigned OVERSAMPLE     = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rx,
  axis_if.m_axis     m_axis,
  output logic       rx_done,
  output logic [1:0] rx_error,
  output logic       overrun
);

  localparam int unsigned DIV     = calc_div(CLOCK, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned N_CHARS = AXI_DATA_WIDTH / DATA_BITS;
  localparam int unsigned IDX_W   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int unsigned BIT_W   = 4;

  // Line synchroniser and edge history
  logic [1:0] sync_q, sync_d;
  logic       rx_prev_q, rx_prev_d;
  logic       rx_s;
  logic       start_edge_c;

  // Frame FSM and bit-level datapath
  rx_state_t            state_q, state_d;
  logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 s7_q, s7_d;
  logic                 s8_q, s8_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 rx_done_q, rx_done_d;
  uart_err_t            rx_error_q, rx_error_d;

  // Word assembly and output register
  logic [AXI_DATA_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]          char_idx_q, char_idx_d;
  logic                      word_done_q, word_done_d;
  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      overrun_q, overrun_d;

  logic tick_c;
  logic restart_c;
  logic vote_c;
  logic mid_c;
  logic end_c;
  logic par_exp_c;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (aclk),
    .rst_n   (aresetn),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Synchroniser; a start needs a 1->0 transition, so a held-low break line
  // is ignored until it has gone high again
  always_comb begin
    sync_d    = {sync_q[0], uart_rx};
    rx_prev_d = sync_q[1];
  end

  assign rx_s         = sync_q[1];
  assign start_edge_c = rx_prev_q & ~rx_s;

  // Vote uses the two stored samples plus the live third sample
  assign vote_c    = vote3(s7_q, s8_q, rx_s);
  assign mid_c     = tick_c && (smp_cnt_q == SAMPLE_C);
  assign end_c     = tick_c && (smp_cnt_q == SAMPLE_LAST);
  assign par_exp_c = (PARITY_BITS == PARITY_ODD) ? ~(^shift_q) : ^shift_q;

  // Frame FSM: next state plus bit-level datapath
  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    rx_done_d  = 1'b0;
    rx_error_d = rx_error_q;
    restart_c  = 1'b0;

    if ((state_q != ST_IDLE) && tick_c) begin
      smp_cnt_d = smp_cnt_q + SMP_W'(1);
      if (smp_cnt_q == SAMPLE_A) s7_d = rx_s;
      if (smp_cnt_q == SAMPLE_B) s8_d = rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          restart_c  = 1'b1;
          smp_cnt_d  = '0;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (mid_c && vote_c) begin
          rx_done_d  = 1'b1;
          rx_error_d = ERR_START;
          state_d    = ST_IDLE;
        end else if (end_c) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (mid_c) begin
          shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
        end
        if (end_c) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_BITS != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (mid_c) begin
          par_err_d = (vote_c != par_exp_c);
        end
        if (end_c) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (mid_c) begin
          if (!vote_c) stop_err_d = 1'b1;
          // Frame closes at mid-point of the last stop bit so a following
          // start bit can arrive with no idle gap
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            rx_done_d = 1'b1;
            state_d   = ST_IDLE;
            if (stop_err_q || !vote_c) begin
              rx_error_d = ERR_STOP;
            end else if (par_err_q) begin
              rx_error_d = ERR_PARITY;
            end else begin
              rx_error_d = ERR_OK;
            end
          end
        end else if (end_c) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word assembly, driven by the registered frame result
  always_comb begin
    asm_d       = asm_q;
    char_idx_d  = char_idx_q;
    word_done_d = 1'b0;

    if (rx_done_q) begin
      if (rx_error_q == ERR_OK) begin
        for (int unsigned i = 0; i < N_CHARS; i++) begin
          if (char_idx_q == IDX_W'(i)) begin
            asm_d[i*DATA_BITS +: DATA_BITS] = shift_q;
          end
        end
        if (char_idx_q == IDX_W'(N_CHARS - 1)) begin
          char_idx_d  = '0;
          word_done_d = 1'b1;
        end else begin
          char_idx_d = char_idx_q + IDX_W'(1);
        end
      end else begin
        char_idx_d = '0;
        asm_d      = '0;
      end
    end
  end

  // Output register: load on completion unless a held word is still stalled
  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = 1'b0;

    if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end
    if (word_done_q) begin
      if (!tvalid_q || m_axis.tready) begin
        tdata_d  = asm_q;
        tvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_error_q  <= ERR_OK;
      asm_q       <= '0;
      char_idx_q  <= '0;
      word_done_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      rx_done_q   <= rx_done_d;
      rx_error_q  <= rx_error_d;
      asm_q       <= asm_d;
      char_idx_q  <= char_idx_d;
      word_done_q <= word_done_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign rx_done       = rx_done_q;
  assign rx_error      = rx_error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx_oversampled.sv
// Bench for axis_uart_rx_oversampled: three instances (8N1/8-bit word,
// 8E1/32-bit word, 8O1/32-bit word) driven one at a time, compared against
// a frame-level model of expected statuses and words.
module tb_axis_uart_rx_oversampled;

  localparam int unsigned CLK_HZ  = 1_600_000;
  localparam int unsigned BAUD    = 10_000;
  localparam int          BIT_CYC = 160;
  localparam int          TIMEOUT = 4000;

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b1;
  logic [2:0] line    = 3'b111;
  logic [2:0] rdy     = 3'b000;
  logic [2:0] done_v, valid_v, ovr_v, sel;
  logic [1:0] err_a, err_b, err_c;

  always #5 aclk = ~aclk;

  axis_if #(.DATA_WIDTH(8))  bus_a ();
  axis_if #(.DATA_WIDTH(32)) bus_b ();
  axis_if #(.DATA_WIDTH(32)) bus_c ();

  assign bus_a.tready = rdy[0];
  assign bus_b.tready = rdy[1];
  assign bus_c.tready = rdy[2];
  assign valid_v = {bus_c.tvalid, bus_b.tvalid, bus_a.tvalid};

  axis_uart_rx_oversampled #(.AXI_DATA_WIDTH(8), .CLOCK(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0), .OVERSAMPLE(16)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .uart_rx(line[0]), .m_axis(bus_a),
    .rx_done(done_v[0]), .rx_error(err_a), .overrun(ovr_v[0]));

  axis_uart_rx_oversampled #(.AXI_DATA_WIDTH(32), .CLOCK(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(1), .OVERSAMPLE(16)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .uart_rx(line[1]), .m_axis(bus_b),
    .rx_done(done_v[1]), .rx_error(err_b), .overrun(ovr_v[1]));

  axis_uart_rx_oversampled #(.AXI_DATA_WIDTH(32), .CLOCK(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(2), .OVERSAMPLE(16)) dut_c (
    .aclk(aclk), .aresetn(aresetn), .uart_rx(line[2]), .m_axis(bus_c),
    .rx_done(done_v[2]), .rx_error(err_c), .overrun(ovr_v[2]));

  // View of the instance under test
  int          act = 0;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  logic        m_valid, m_ready, m_done, m_ovr;

  assign sel = 3'b001 << act;

  always_comb begin
    case (act)
      1: begin
        m_data = bus_b.tdata; m_err = err_b; m_valid = bus_b.tvalid;
        m_ready = rdy[1]; m_done = done_v[1]; m_ovr = ovr_v[1];
      end
      2: begin
        m_data = bus_c.tdata; m_err = err_c; m_valid = bus_c.tvalid;
        m_ready = rdy[2]; m_done = done_v[2]; m_ovr = ovr_v[2];
      end
      default: begin
        m_data = 32'(bus_a.tdata); m_err = err_a; m_valid = bus_a.tvalid;
        m_ready = rdy[0]; m_done = done_v[0]; m_ovr = ovr_v[0];
      end
    endcase
  end

  // Model state
  logic [1:0]  exp_err[$];
  logic [31:0] exp_word[$];
  int          pending = 0, exp_ovr = 0, ovr_seen = 0, words_seen = 0;
  logic [31:0] part = 32'd0;
  int          idx = 0;
  logic [31:0] last_word = 32'd0;
  int          nch_cfg[3] = '{1, 4, 4};
  int          par_cfg[3] = '{0, 1, 2};
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Continuous comparison against the model
  logic [1:0]  last_err  = 2'b00;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = 32'd0;

  always @(negedge aclk) begin
    logic [1:0]  e;
    logic [31:0] w;
    if (!aresetn) begin
      last_err  = 2'b00;
      hold_prev = 1'b0;
    end else begin
      check("quiet_others", 32'((done_v | valid_v | ovr_v) & ~sel), 32'd0);
      if (m_done) begin
        if (exp_err.size() == 0) begin
          check("rx_done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_err.pop_front();
          check("rx_error", 32'(m_err), 32'(e));
          last_err = e;
        end
      end else begin
        check("rx_error_held", 32'(m_err), 32'(last_err));
      end
      if (hold_prev) begin
        check("tvalid_held", 32'(m_valid), 32'd1);
        check("tdata_stable", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        if (exp_word.size() == 0) begin
          check("word_unexpected", 32'd1, 32'd0);
        end else begin
          w = exp_word.pop_front();
          check("tdata", m_data, w);
          pending--;
        end
        words_seen++;
        last_word = m_data;
      end
      if (m_ovr) ovr_seen++;
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Frame-level model: status per frame, words built LSB-character-first
  task automatic model_char(input logic [7:0] ch, input logic [1:0] err);
    exp_err.push_back(err);
    if (err != 2'b00) begin
      idx  = 0;
      part = 32'd0;
    end else begin
      part = part | (32'(ch) << (8 * idx));
      idx++;
      if (idx == nch_cfg[act]) begin
        if (!rdy[act] && pending > 0) begin
          exp_ovr++;
        end else begin
          exp_word.push_back(part);
          pending++;
        end
        idx  = 0;
        part = 32'd0;
      end
    end
  endtask

  task automatic drive_bit(input logic b, input bit noise);
    for (int c = 0; c < BIT_CYC; c++) begin
      line[act] = (noise && c >= 88 && c < 96) ? ~b : b;
      tick_n(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] ch, input bit bad_par, input bit bad_stop,
                            input bit noise);
    logic p;
    model_char(ch, bad_stop ? 2'b10 : ((bad_par && par_cfg[act] != 0) ? 2'b11 : 2'b00));
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ch[i], noise);
    if (par_cfg[act] != 0) begin
      p = (par_cfg[act] == 1) ? ^ch : ~(^ch);
      drive_bit(p ^ bad_par, 1'b0);
    end
    drive_bit(!bad_stop, 1'b0);
  endtask

  task automatic wait_sig(input bit want_valid, input string name, output int at);
    at = -1;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge aclk);
      if (want_valid ? m_valid : m_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int t_done, t_valid, w0, o0;

    // Reset values on every instance
    #2 aresetn = 1'b0;
    tick_n(4);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_valid", 32'(valid_v), 32'd0);
    check("rst_overrun", 32'(ovr_v), 32'd0);
    check("rst_err", 32'({err_c, err_b, err_a}), 32'd0);
    check("rst_tdata_a", 32'(bus_a.tdata), 32'd0);
    check("rst_tdata_b", bus_b.tdata, 32'd0);
    aresetn = 1'b1;
    tick_n(20);

    // 8N1 single char, stalled sink, latency from rx_done to tvalid
    act = 0;
    rdy = 3'b000;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      begin
        wait_sig(1'b0, "a5_done", t_done);
        wait_sig(1'b1, "a5_valid", t_valid);
        if (t_done >= 0 && t_valid >= 0) check("latency", 32'(t_valid - t_done), 32'd2);
        check("a5_tdata_lit", m_data, 32'h0000_00A5);
        check("a5_err_lit", 32'(m_err), 32'd0);
      end
    join
    tick_n(40);
    check("a5_still_valid", 32'(m_valid), 32'd1);
    rdy[0] = 1'b1;
    tick_n(3);
    check("a5_cleared", 32'(m_valid), 32'd0);

    // Noise spikes at the centre sample of every data bit
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    tick_n(40);
    check("noise_last_lit", last_word, 32'h0000_00C3);

    // 60-cycle low glitch -> start error; forced-low stop -> stop error
    model_char(8'h00, 2'b01);
    for (int c = 0; c < 60; c++) begin
      line[0] = 1'b0;
      tick_n(1);
    end
    line[0] = 1'b1;
    tick_n(2 * BIT_CYC);
    check("glitch_err_lit", 32'(m_err), 32'h1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    line[0] = 1'b1;
    tick_n(2 * BIT_CYC);
    check("stop_err_lit", 32'(m_err), 32'h2);

    // Two words into a stalled sink: first held, second dropped
    rdy[0] = 1'b0;
    o0 = ovr_seen;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    tick_n(40);
    check("ovr_count_lit", 32'(ovr_seen - o0), 32'd1);
    check("ovr_model", 32'(ovr_seen), 32'(exp_ovr));
    check("ovr_held_lit", m_data, 32'h0000_0011);
    rdy[0] = 1'b1;
    tick_n(3);
    check("ovr_drained", 32'(m_valid), 32'd0);
    check("ovr_xfer_lit", last_word, 32'h0000_0011);

    // Reset in the middle of the data bits
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    tick_n(50);
    aresetn = 1'b0;
    tick_n(1);
    check("midrst_done", 32'(m_done), 32'd0);
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_err", 32'(m_err), 32'd0);
    check("midrst_ovr", 32'(m_ovr), 32'd0);
    check("midrst_tdata", m_data, 32'd0);
    line[0] = 1'b1;
    idx = 0; part = 32'd0; pending = 0;
    tick_n(5);
    aresetn = 1'b1;
    tick_n(BIT_CYC);
    send_frame(8'hE7, 1'b0, 1'b0, 1'b0);
    tick_n(40);
    check("after_rst_lit", last_word, 32'h0000_00E7);

    // 8E1, four back-to-back chars into one 32-bit word
    act = 1;
    rdy = 3'b111;
    tick_n(20);
    w0 = words_seen;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0, 1'b0);
    tick_n(40);
    check("e1_word_count", 32'(words_seen - w0), 32'd1);
    check("e1_word_lit", last_word, 32'h4433_2211);

    // 8O1, parity error on the 2nd char discards the partial word
    act = 2;
    tick_n(20);
    w0 = words_seen;
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    tick_n(10);
    check("par_err_lit", 32'(m_err), 32'h3);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h04, 1'b0, 1'b0, 1'b0);
    check("o1_no_word", 32'(words_seen - w0), 32'd0);
    send_frame(8'hA1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hD4, 1'b0, 1'b0, 1'b0);
    tick_n(40);
    check("o1_word_count", 32'(words_seen - w0), 32'd1);
    check("o1_word_lit", last_word, 32'hB2A1_0403);

    // Everything the model expected has been seen
    tick_n(100);
    check("err_queue_empty", 32'(exp_err.size()), 32'd0);
    check("word_queue_empty", 32'(exp_word.size()), 32'd0);
    check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
